fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of a FIFO word.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, the width of the burst length.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle burst request; sampled in IDLE only.
REQ-006 SHALL have port burst_len  input  LEN_WIDTH  number of words in the burst; latched when start is accepted.
REQ-007 SHALL have port fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-008 SHALL have port fifo_data  input  DATA_WIDTH  registered read data of the upstream FIFO; valid the cycle after a read.
REQ-009 SHALL have port fifo_rd_enable  output  1  read strobe to the upstream FIFO.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  head word of the output stream.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word; a transfer occurs when out_valid && out_ready.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a burst completes.

Function
REQ-015 SHALL implement the states IDLE, READ and DRAIN.
REQ-016 IDLE: start with burst_len != 0 -> READ next cycle; the length is latched and issue_cnt and deliver_cnt are cleared.
REQ-017 IDLE: start with burst_len == 0 -> stay in IDLE; done pulses the next cycle; no read is issued.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 fifo_rd_enable SHALL be combinational: (state == READ) && !fifo_empty && issue_cnt < len && (occ + inflight - pop) < 2.
REQ-020 Terms in REQ-019: occ is the buffer occupancy 0..2; inflight is the registered fifo_rd_enable of the previous cycle; pop is out_valid && out_ready.
REQ-021 fifo_rd_enable SHALL never be asserted while fifo_empty is high, so that every asserted strobe is a real read.
REQ-022 The cycle after fifo_rd_enable is high, fifo_data SHALL be written into the tail of a 2-entry in-order buffer.
REQ-023 The buffer SHALL support a simultaneous write and pop in the same cycle.
REQ-024 out_valid SHALL equal occ != 0, and out_data SHALL be the head entry, driven from registers.
REQ-025 out_data SHALL hold stable while out_valid && !out_ready.
REQ-026 READ -> DRAIN in the cycle after the strobe that makes issue_cnt equal len.
REQ-027 DRAIN -> IDLE when deliver_cnt equals len; done SHALL pulse in the first IDLE cycle.
REQ-028 Latency: start in cycle 0 gives fifo_rd_enable in cycle 1 and out_valid in cycle 3.
REQ-029 With fifo_empty low and out_ready held high, one word SHALL be delivered per cycle after the first word.
REQ-030 Counters SHALL be LEN_WIDTH bits and SHALL not wrap, because len is at most 2^LEN_WIDTH - 1.
REQ-031 If the FIFO goes empty mid-burst, the block SHALL wait in READ with no timeout.

Reset
REQ-032 While reset is high: state = IDLE, occ = 0, inflight = 0, counters = 0, fifo_rd_enable = 0, out_valid = 0, busy = 0, done = 0, out_data = 0.
REQ-033 Reset mid-burst SHALL discard any buffered word and any word in flight; no word is delivered after reset deasserts unless a new start is accepted.

Structure
REQ-034 The state enum and the buffer depth constant (2) SHALL live in the shared package fifo_reader_pkg.
REQ-035 The 2-entry buffer SHALL be a sub-module named fifo_reader_buf, with ports for write, pop, head data and occupancy.

Verification
REQ-036 Scenario 1: FIFO holds 0x11,0x22,0x33; start with burst_len=3; out_ready=1 -> out_data is 0x11,0x22,0x33 on consecutive cycles starting in cycle 3; done pulses once; exactly 3 strobes.
REQ-037 Scenario 2: burst_len=4; out_ready low for cycles 3-8 -> occ holds at 2 and no more than 2 strobes are issued before the first pop; data order is preserved; out_data is stable while stalled.
REQ-038 Scenario 3: fifo_empty high for 5 cycles after the 1st word of a burst_len=2 burst -> no strobe during the empty window; the burst completes after refill; done pulses.
REQ-039 Scenario 4: start with burst_len=0 -> done pulses the next cycle; busy stays 0; no strobe.
REQ-040 Scenario 5: reset asserted during DRAIN with occ=2 -> the next cycle has out_valid=0 and state IDLE; no done pulse; start during READ is ignored and does not change len.
REQ-041 Scenario 6: burst_len=255 with random out_ready and fifo_empty -> 255 words are delivered in order; strobe count is 255; fifo_rd_enable is never high while fifo_empty is high.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO burst reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order skid buffer; head is always slot 0 so out data comes straight from a register.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_WIDTH-1:0]  occ
);

  localparam logic [OCC_WIDTH-1:0] OCC_ONE = OCC_WIDTH'(1);

  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({write, pop})
        2'b10: begin
          if (occ == '0) head <= wdata;
          else           tail <= wdata;
          occ <= occ + OCC_ONE;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - OCC_ONE;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever survives the pop.
          if (occ == OCC_ONE) begin
            head <= wdata;
          end else begin
            head <= tail;
            tail <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Reads a burst of burst_len words from a registered-output FIFO and streams them out with valid/ready.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [OCC_WIDTH:0]     DEPTH_LIM = (OCC_WIDTH + 1)'(BUF_DEPTH);

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   issue_cnt;
  logic [LEN_WIDTH-1:0]   deliver_cnt;
  logic                   inflight;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   pop;
  logic [OCC_WIDTH:0]     pending;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != '0);
  assign busy      = (state != ST_IDLE);

  // Words already buffered plus the one in flight, minus the one leaving now, must leave a free slot.
  assign pending = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight} - {{OCC_WIDTH{1'b0}}, pop};

  assign fifo_rd_enable = !reset && (state == ST_READ) && !fifo_empty &&
                          (issue_cnt < len) && (pending < DEPTH_LIM);

  fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .write (inflight),
    .wdata (fifo_data),
    .pop   (pop),
    .head  (out_data),
    .occ   (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      len         <= '0;
      issue_cnt   <= '0;
      deliver_cnt <= '0;
      inflight    <= 1'b0;
      done        <= 1'b0;
    end else begin
      inflight <= fifo_rd_enable;
      done     <= 1'b0;
      if (fifo_rd_enable) issue_cnt   <= issue_cnt + LEN_ONE;
      if (pop)            deliver_cnt <= deliver_cnt + LEN_ONE;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state       <= ST_READ;
              len         <= burst_len;
              issue_cnt   <= '0;
              deliver_cnt <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (fifo_rd_enable && (issue_cnt + LEN_ONE == len)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (deliver_cnt == len) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural registered-output FIFO upstream.
module tb_fifo_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_enable;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic          force_empty;
  int            fcount;
  logic [DW-1:0] fq[$];

  int n_checks = 0;
  int n_errors = 0;

  int   ncyc = 0, t0 = 0;
  int   strobes = 0, bad_strobes = 0, dones = 0, last_done = -1;
  logic rd_last = 1'b0;
  logic [DW-1:0] got[$];
  int   got_cyc[$];

  int s_base, g_base, d_base;

  assign fifo_empty = force_empty || (fcount == 0);

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_len      (burst_len),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_rd_enable (fifo_rd_enable),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  // Observe the DUT mid-cycle; cycle numbers are relative to the last start.
  always @(negedge clk) begin
    rd_last = fifo_rd_enable;
    if (!reset) begin
      if (fifo_rd_enable) begin
        strobes++;
        if (fifo_empty) bad_strobes++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(ncyc - t0);
      end
      if (done) begin
        dones++;
        last_done = ncyc - t0;
      end
    end
    ncyc++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; the FIFO model presents read data the cycle after a strobe.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rd_last && fq.size() > 0) fifo_data = fq.pop_front();
    fcount = fq.size();
    #1;
  endtask

  task automatic wait_to(input int k);
    while (ncyc - t0 < k) cyc();
  endtask

  task automatic kick(input logic [LW-1:0] n);
    start     = 1'b1;
    burst_len = n;
    t0        = ncyc;
    s_base    = strobes;
    g_base    = got.size();
    d_base    = dones;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] gw(input int idx);
    if (idx < got.size()) return got[idx];
    return 'x;
  endfunction

  function automatic int gc(input int idx);
    if (idx < got_cyc.size()) return got_cyc[idx];
    return -1;
  endfunction

  logic [DW-1:0] exp_w[$];
  int nbad;

  initial begin
    reset = 1'b1; start = 1'b0; burst_len = '0; out_ready = 1'b1;
    force_empty = 1'b0; fcount = 0; fifo_data = '0;
    cyc(); cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_en", fifo_rd_enable, 0);
    reset = 1'b0;
    cyc();

    // Scenario 1: three words streamed back to back.
    fq = '{8'h11, 8'h22, 8'h33}; fcount = fq.size();
    kick(3);
    check("s1_rd_c1", fifo_rd_enable, 1);
    check("s1_busy_c1", busy, 1);
    cyc();
    check("s1_valid_c2", out_valid, 0);
    cyc();
    check("s1_valid_c3", out_valid, 1);
    check("s1_data_c3", out_data, 8'h11);
    wait_to(12);
    exp_w = '{8'h11, 8'h22, 8'h33};
    check("s1_count", got.size() - g_base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s1_word%0d", i), gw(g_base + i), exp_w[i]);
      check($sformatf("s1_cyc%0d", i), gc(g_base + i), 3 + i);
    end
    check("s1_strobes", strobes - s_base, 3);
    check("s1_dones", dones - d_base, 1);
    check("s1_done_cyc", last_done, 7);

    // Scenario 2: downstream stalls cycles 3-8.
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4}; fcount = fq.size();
    kick(4);
    for (int k = 1; k <= 18; k++) begin
      out_ready = !(k >= 3 && k <= 8);
      if (k == 5 || k == 8) begin
        check($sformatf("s2_occ_c%0d", k), dut.occ, 2);
        check($sformatf("s2_valid_c%0d", k), out_valid, 1);
        check($sformatf("s2_hold_c%0d", k), out_data, 8'hA1);
        check($sformatf("s2_strobes_c%0d", k), strobes - s_base, 2);
      end
      cyc();
    end
    exp_w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    check("s2_count", got.size() - g_base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2_word%0d", i), gw(g_base + i), exp_w[i]);
      check($sformatf("s2_cyc%0d", i), gc(g_base + i), 9 + i);
    end
    check("s2_strobes", strobes - s_base, 4);
    check("s2_done_cyc", last_done, 14);

    // Scenario 3: FIFO runs dry for cycles 2-6.
    fq = '{8'hB1, 8'hB2}; fcount = fq.size();
    kick(2);
    cyc();
    force_empty = 1'b1;
    wait_to(7);
    force_empty = 1'b0;
    check("s3_strobes_dry", strobes - s_base, 1);
    wait_to(14);
    check("s3_count", got.size() - g_base, 2);
    check("s3_word0", gw(g_base), 8'hB1);
    check("s3_word1", gw(g_base + 1), 8'hB2);
    check("s3_cyc0", gc(g_base), 3);
    check("s3_cyc1", gc(g_base + 1), 9);
    check("s3_dones", dones - d_base, 1);
    check("s3_done_cyc", last_done, 11);

    // Scenario 4: zero-length burst.
    fq = '{8'hEE}; fcount = fq.size();
    kick(0);
    check("s4_done_c1", done, 1);
    check("s4_busy_c1", busy, 0);
    cyc();
    check("s4_done_c2", done, 0);
    check("s4_busy_c2", busy, 0);
    wait_to(5);
    check("s4_strobes", strobes - s_base, 0);
    check("s4_done_cyc", last_done, 1);

    // Scenario 5: start ignored in READ, then reset while DRAIN holds two words.
    fq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4}; fcount = fq.size();
    out_ready = 1'b0;
    kick(2);
    start = 1'b1; burst_len = 8'd5;
    cyc();
    start = 1'b0;
    wait_to(5);
    check("s5_len", dut.len, 2);
    check("s5_occ", dut.occ, 2);
    check("s5_busy", busy, 1);
    check("s5_strobes", strobes - s_base, 2);
    reset = 1'b1;
    cyc();
    check("s5_rst_valid", out_valid, 0);
    check("s5_rst_busy", busy, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    wait_to(14);
    check("s5_no_words", got.size() - g_base, 0);
    check("s5_no_done", dones - d_base, 0);

    // Scenario 6: full-length burst under random stalls on both sides.
    fq.delete();
    exp_w.delete();
    for (int i = 0; i < 255; i++) begin
      exp_w.push_back(DW'(i * 37 + 5));
      fq.push_back(DW'(i * 37 + 5));
    end
    fcount = fq.size();
    out_ready = 1'b1; force_empty = 1'b0;
    kick(8'd255);
    for (int k = 0; k < 4000 && dones == d_base; k++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      cyc();
    end
    force_empty = 1'b0; out_ready = 1'b1;
    check("s6_done", dones - d_base, 1);
    check("s6_count", got.size() - g_base, 255);
    nbad = 0;
    for (int i = 0; i < 255; i++)
      if (gw(g_base + i) !== exp_w[i]) nbad++;
    check("s6_order", nbad, 0);
    check("s6_strobes", strobes - s_base, 255);
    check("no_strobe_when_empty", bad_strobes, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
